// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// MemAccessStage (module mem_access_stage)
//
// MIPS MEM stage. Holds the EX/MEM pipeline latch, resolves conditional
// branches, drives a variable-latency data memory over valid/ready request
// and response handshakes, and produces one registered writeback record per
// retired instruction. The upstream pipeline is stalled while a memory access
// is outstanding.
//
// Parameters
//   TIMEOUT_CYCLES : max cycles waiting for a load response (0 = never abort)
//   TMO_W          : width of the timeout counter (TIMEOUT_CYCLES < 2**TMO_W)
//
// Ports
//   clk, rst_n               : clock (rising edge), async active-low reset
//   ivalid, iSig_*           : execute-stage instruction and control bits
//   iadder_branch_result     : branch target
//   iALU_zero, iALU_result   : ALU flag and result (result = memory address)
//   ireg_write_reg           : destination register
//   itemp_regfile_2          : store data
//   ostall                   : hold upstream stages
//   opc_src, obranch_target  : branch taken / redirect PC
//   dmem_req_*, dmem_we,
//   dmem_addr, dmem_wdata    : data-memory request channel
//   dmem_rsp_valid,
//   dmem_rdata               : data-memory response channel
//   owb_*                    : writeback record (owb_valid is a 1-cycle pulse)
//   omisaligned, obus_error  : 1-cycle event pulses
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ivalid,
  input  logic        iSig_Branch,
  input  logic        iSig_MemRead,
  input  logic        iSig_MemWrite,
  input  logic        iSig_RegWrite,
  input  logic        iSig_MemtoReg,
  input  logic [31:0] iadder_branch_result,
  input  logic        iALU_zero,
  input  logic [31:0] iALU_result,
  input  logic [4:0]  ireg_write_reg,
  input  logic [31:0] itemp_regfile_2,
  output logic        ostall,
  output logic        opc_src,
  output logic [31:0] obranch_target,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        owb_valid,
  output logic        owb_RegWrite,
  output logic [4:0]  owb_write_reg,
  output logic [31:0] owb_data,
  output logic        omisaligned,
  output logic        obus_error
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  // Counter value on the last permitted waiting cycle; irrelevant when the
  // timeout is disabled because tmo_hit is then forced low.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  logic [TMO_W-1:0]  tmo_cnt;

  // EX/MEM latch contents
  logic        lv;
  logic        l_branch;
  logic        l_zero;
  logic        l_regwrite;
  logic        l_memtoreg;
  logic        l_memwrite;
  logic        l_mis;
  logic [31:0] l_target;
  logic [31:0] l_alu;
  logic [4:0]  l_wreg;
  logic [31:0] l_wdata;

  // Combinational decode of the current cycle
  logic        memop;
  logic        misaligned_in;
  logic        tmo_hit;
  logic        retire;
  logic        mem_done;
  logic        ret_regwrite;
  logic        ret_mis;
  logic        ret_buserr;
  logic [31:0] ret_data;

  assign misaligned_in = ivalid & (iSig_MemRead | iSig_MemWrite) & (iALU_result[1:0] != 2'b00);
  assign memop         = ivalid & (iSig_MemRead | iSig_MemWrite) & (iALU_result[1:0] == 2'b00);
  assign tmo_hit       = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

  assign ostall         = (state != IDLE);
  assign opc_src        = lv & l_branch & l_zero;
  assign obranch_target = l_target;
  assign dmem_req_valid = (state == REQ);
  assign dmem_we        = l_memwrite;
  assign dmem_addr      = {l_alu[31:2], 2'b00};
  assign dmem_wdata     = l_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the retire decision. In IDLE a valid latch can only hold
  // a non-memory (or misaligned, hence suppressed) instruction, because an
  // aligned memory op moves the FSM to REQ on its capture edge. Memory ops
  // clear lv when they retire so they are not retired a second time.
  // A response on the timeout edge takes precedence over the abort.
  always_comb begin
    state_next   = state;
    retire       = 1'b0;
    mem_done     = 1'b0;
    ret_regwrite = 1'b0;
    ret_mis      = 1'b0;
    ret_buserr   = 1'b0;
    ret_data     = l_alu;
    case (state)
      IDLE: begin
        if (lv) begin
          retire       = 1'b1;
          ret_regwrite = l_regwrite & ~l_mis;
          ret_mis      = l_mis;
        end
        if (memop) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (dmem_req_ready) begin
          if (l_memwrite) begin
            retire     = 1'b1;
            mem_done   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (dmem_rsp_valid) begin
          retire       = 1'b1;
          mem_done     = 1'b1;
          ret_regwrite = l_regwrite;
          ret_data     = l_memtoreg ? dmem_rdata : l_alu;
          state_next   = IDLE;
        end else if (tmo_hit) begin
          retire     = 1'b1;
          mem_done   = 1'b1;
          ret_buserr = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pipeline latch: loads whenever the stage is not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lv         <= 1'b0;
      l_branch   <= 1'b0;
      l_zero     <= 1'b0;
      l_regwrite <= 1'b0;
      l_memtoreg <= 1'b0;
      l_memwrite <= 1'b0;
      l_mis      <= 1'b0;
      l_target   <= '0;
      l_alu      <= '0;
      l_wreg     <= '0;
      l_wdata    <= '0;
    end else if (state == IDLE) begin
      lv         <= ivalid;
      l_branch   <= iSig_Branch;
      l_zero     <= iALU_zero;
      l_regwrite <= iSig_RegWrite;
      l_memtoreg <= iSig_MemtoReg;
      l_memwrite <= iSig_MemWrite;
      l_mis      <= misaligned_in;
      l_target   <= iadder_branch_result;
      l_alu      <= iALU_result;
      l_wreg     <= ireg_write_reg;
      l_wdata    <= itemp_regfile_2;
    end else if (mem_done) begin
      lv <= 1'b0;
    end
  end

  // Timeout counter: restarted when a load is accepted, counts idle
  // waiting cycles until the response or the abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == REQ && dmem_req_ready) begin
      tmo_cnt <= '0;
    end else if (state == WAIT_RSP && !dmem_rsp_valid && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Writeback register: event flags pulse for one cycle, data fields hold
  // their last value between retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owb_valid     <= 1'b0;
      owb_RegWrite  <= 1'b0;
      owb_write_reg <= '0;
      owb_data      <= '0;
      omisaligned   <= 1'b0;
      obus_error    <= 1'b0;
    end else begin
      owb_valid   <= retire;
      omisaligned <= ret_mis;
      obus_error  <= ret_buserr;
      if (retire) begin
        owb_RegWrite  <= ret_regwrite;
        owb_write_reg <= l_wreg;
        owb_data      <= ret_data;
      end
    end
  end

endmodule
